note_mapper: RTL and testbench

- Sits directly downstream of fftdec in the tuner datapath.
- Consumes fftdec's dominant-frequency result (frequency, note_dec) and classifies it to the nearest equal-tempered semitone, C2..B6 (60 notes).
- Applies a consecutive-hit stability filter before presenting a note to the display/UI stage.
- Classification is a sequential threshold scan against a ROM. Pitch class and octave come from running counters; no divider is used.

---
 rtl/note_mapper_if.sv | 30 +++
 rtl/note_mapper.sv | 191 +++++++++++++++++++
 tb/tb_note_mapper.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/note_mapper_if.sv
// Tuner bus between fftdec (master side) and note_mapper (slave side).
// Optional tune output is driven only when note_mapper is built with NOTE_TUNE_EN.
`timescale 1ns/1ps
interface note_mapper_if #(
  parameter int BIT_WIDTH = 16
);
  // note_dec is a level, not a valid/ready pair: each 0->1 transition seen while the
  // mapper is idle requests one classification of the frequency present on that same
  // clock edge; busy reports an ongoing classification, and transitions while busy are
  // dropped (there is no back-pressure, the producer is never stalled).
  logic [BIT_WIDTH:0] frequency;
  logic               note_dec;
  logic               busy;
  logic               note_valid;
  logic               note_change;
  logic [6:0]         midi_note;
  logic [3:0]         pitch_class;
  logic [2:0]         octave;
  logic [1:0]         tune;

  modport master (
    output frequency, note_dec,
    input  busy, note_valid, note_change, midi_note, pitch_class, octave, tune
  );

  modport slave (
    input  frequency, note_dec,
    output busy, note_valid, note_change, midi_note, pitch_class, octave, tune
  );
endinterface

// File: rtl/note_mapper.sv
// Maps fftdec's dominant frequency to the nearest semitone C2..B6 via a threshold-ROM scan,
// then publishes it through a consecutive-hit stability filter. Macro NOTE_TUNE_EN adds sharp/flat.
`timescale 1ns/1ps
module note_mapper #(
  parameter int BIT_WIDTH    = 16,
  parameter int NUM_NOTES    = 60,
  parameter int STABLE_COUNT = 3,
  parameter int TUNE_TOL     = 2
) (
  input  logic               clk,
  input  logic               reset,
  note_mapper_if.slave       bus,
  output logic [1:0]         dbg_state
);
  localparam int FW = BIT_WIDTH + 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [FW-1:0] LO_EDGE = FW'(64);
  localparam logic [5:0]    NONE    = 6'd63;

  // Upper edge of each note, padded to 64 entries so any 6-bit index is in range.
  localparam logic [11:0] THR [0:63] = '{
    12'd67,   12'd71,   12'd76,   12'd80,   12'd85,   12'd90,   12'd95,   12'd101,  12'd107,  12'd113,
    12'd120,  12'd127,  12'd135,  12'd143,  12'd151,  12'd160,  12'd170,  12'd180,  12'd190,  12'd202,
    12'd214,  12'd226,  12'd240,  12'd254,  12'd269,  12'd285,  12'd302,  12'd320,  12'd339,  12'd359,
    12'd381,  12'd403,  12'd427,  12'd453,  12'd480,  12'd508,  12'd539,  12'd571,  12'd605,  12'd640,
    12'd679,  12'd719,  12'd762,  12'd807,  12'd855,  12'd906,  12'd960,  12'd1017, 12'd1077, 12'd1141,
    12'd1209, 12'd1281, 12'd1357, 12'd1438, 12'd1523, 12'd1614, 12'd1710, 12'd1812, 12'd1919, 12'd2033,
    12'd0,    12'd0,    12'd0,    12'd0
  };

`ifdef NOTE_TUNE_EN
  localparam logic [11:0] CTR [0:63] = '{
    12'd65,   12'd69,   12'd73,   12'd78,   12'd82,   12'd87,   12'd92,   12'd98,   12'd104,  12'd110,
    12'd117,  12'd123,  12'd131,  12'd139,  12'd147,  12'd156,  12'd165,  12'd175,  12'd185,  12'd196,
    12'd208,  12'd220,  12'd233,  12'd247,  12'd262,  12'd277,  12'd294,  12'd311,  12'd330,  12'd349,
    12'd370,  12'd392,  12'd415,  12'd440,  12'd466,  12'd494,  12'd523,  12'd554,  12'd587,  12'd622,
    12'd659,  12'd698,  12'd740,  12'd784,  12'd831,  12'd880,  12'd932,  12'd988,  12'd1047, 12'd1109,
    12'd1175, 12'd1245, 12'd1319, 12'd1397, 12'd1480, 12'd1568, 12'd1661, 12'd1760, 12'd1865, 12'd1976,
    12'd0,    12'd0,    12'd0,    12'd0
  };
  logic [FW-1:0] ctr_k;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RANGE = 2'd1, SCAN = 2'd2, FILTER = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          note_dec_q;
  logic [FW-1:0] f_q, f_d;
  logic [5:0]    k_q, k_d, last_q, last_d;
  logic [3:0]    pc_q, pc_d, pitch_class_q, pitch_class_d;
  logic [2:0]    oct_q, oct_d, octave_q, octave_d;
  logic          none_q, none_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          note_valid_q, note_valid_d, note_change_q, note_change_d;
  logic [6:0]    midi_note_q, midi_note_d, midi_k;
  logic [1:0]    tune_q, tune_d;
  logic          start;
  logic [5:0]    cls;
  logic [FW-1:0] thr_k, thr_top;

  always_comb begin
    state_d       = state_q;
    f_d           = f_q;
    k_d           = k_q;
    pc_d          = pc_q;
    oct_d         = oct_q;
    none_d        = none_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    note_valid_d  = note_valid_q;
    note_change_d = 1'b0;
    midi_note_d   = midi_note_q;
    pitch_class_d = pitch_class_q;
    octave_d      = octave_q;
    tune_d        = tune_q;
    start         = bus.note_dec & ~note_dec_q & (state_q == IDLE);
    cls           = none_q ? NONE : k_q;
    midi_k        = 7'd36 + {1'b0, k_q};
    thr_k         = FW'(THR[k_q]);
    thr_top       = FW'(THR[6'(NUM_NOTES - 1)]);
`ifdef NOTE_TUNE_EN
    ctr_k         = FW'(CTR[k_q]);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          f_d     = bus.frequency;
          k_d     = 6'd0;
          pc_d    = 4'd0;
          oct_d   = 3'd0;
          state_d = RANGE;
        end
      end
      RANGE: begin
        none_d  = (f_q < LO_EDGE) || (f_q >= thr_top);
        state_d = none_d ? FILTER : SCAN;
      end
      SCAN: begin
        if (f_q < thr_k) begin
          state_d = FILTER;
        end else begin
          k_d = k_q + 6'd1;
          if (pc_q == 4'd11) begin
            pc_d  = 4'd0;
            oct_d = oct_q + 3'd1;
          end else begin
            pc_d = pc_q + 4'd1;
          end
        end
      end
      FILTER: begin
        state_d = IDLE;
        if (cls == last_q) begin
          cnt_d = (cnt_q == CW'(STABLE_COUNT)) ? cnt_q : cnt_q + CW'(1);
        end else begin
          last_d = cls;
          cnt_d  = CW'(1);
        end
        if (cnt_d == CW'(STABLE_COUNT)) begin
          if (!none_q) begin
            if (!note_valid_q || (midi_note_q != midi_k)) begin
              midi_note_d   = midi_k;
              pitch_class_d = pc_q;
              octave_d      = oct_q + 3'd2;
              note_valid_d  = 1'b1;
              note_change_d = 1'b1;
            end
          end else begin
            note_valid_d = 1'b0;
            tune_d       = 2'b00;
          end
        end
`ifdef NOTE_TUNE_EN
        // Tune tracks the live frequency only while it matches the note on display.
        if (!none_q && note_valid_d && (midi_note_d == midi_k)) begin
          if (f_q > ctr_k + FW'(TUNE_TOL))      tune_d = 2'b01;
          else if (f_q < ctr_k - FW'(TUNE_TOL)) tune_d = 2'b10;
          else                                  tune_d = 2'b00;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      note_dec_q    <= 1'b0;
      f_q           <= '0;
      k_q           <= 6'd0;
      pc_q          <= 4'd0;
      oct_q         <= 3'd0;
      none_q        <= 1'b0;
      last_q        <= NONE;
      cnt_q         <= '0;
      note_valid_q  <= 1'b0;
      note_change_q <= 1'b0;
      midi_note_q   <= 7'd0;
      pitch_class_q <= 4'd0;
      octave_q      <= 3'd0;
      tune_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      note_dec_q    <= bus.note_dec;
      f_q           <= f_d;
      k_q           <= k_d;
      pc_q          <= pc_d;
      oct_q         <= oct_d;
      none_q        <= none_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      note_valid_q  <= note_valid_d;
      note_change_q <= note_change_d;
      midi_note_q   <= midi_note_d;
      pitch_class_q <= pitch_class_d;
      octave_q      <= octave_d;
      tune_q        <= tune_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.note_valid  = note_valid_q;
  assign bus.note_change = note_change_q;
  assign bus.midi_note   = midi_note_q;
  assign bus.pitch_class = pitch_class_q;
  assign bus.octave      = octave_q;
  assign bus.tune        = tune_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_note_mapper.sv
// Bench for note_mapper: real-valued note model feeds an expected queue, one entry per note_dec edge.
`timescale 1ns/1ps
module tb_note_mapper;
  localparam int BW  = 16;
  localparam int SC  = 3;
  localparam int TOL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [17:0] exp_q[$];

  // Reference model state; class -1 means NONE.
  int m_last, m_cnt, m_pub, m_valid, m_midi, m_pc, m_oct, m_tune;

  always #5 clk = ~clk;

  note_mapper_if #(.BIT_WIDTH(BW)) bus ();

  note_mapper #(
    .BIT_WIDTH(BW), .NUM_NOTES(60), .STABLE_COUNT(SC), .TUNE_TOL(TOL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int ref_thr(input int k);
    real x;
    x = 440.0 * $pow(2.0, (k - 33) / 12.0) * $pow(2.0, 1.0 / 24.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int ref_ctr(input int k);
    real x;
    x = 440.0 * $pow(2.0, (k - 33) / 12.0);
    return $rtoi(x + 0.5);
  endfunction

  function automatic int classify(input int f);
    if (f < 64 || f >= ref_thr(59)) return -1;
    for (int k = 0; k < 60; k++) if (f < ref_thr(k)) return k;
    return -1;
  endfunction

  function automatic logic [17:0] pack_exp(input int v, input int chg);
    return {v[0], chg[0], m_midi[6:0], m_pc[3:0], m_oct[2:0], m_tune[1:0]};
  endfunction

  task automatic model_reset();
    m_last = -1; m_cnt = 0; m_pub = -1; m_valid = 0;
    m_midi = 0; m_pc = 0; m_oct = 0; m_tune = 0;
  endtask

  task automatic model_step(input int f);
    int cls, chg;
    cls = classify(f);
    chg = 0;
    if (cls == m_last) m_cnt = (m_cnt < SC) ? m_cnt + 1 : SC;
    else begin m_last = cls; m_cnt = 1; end
    if (m_cnt == SC && cls >= 0 && (!m_valid || cls != m_pub)) begin
      m_pub = cls; m_valid = 1; chg = 1;
      m_midi = 36 + cls; m_pc = cls % 12; m_oct = cls / 12 + 2;
    end else if (m_cnt == SC && cls < 0) begin
      m_valid = 0; m_tune = 0;
    end
`ifdef NOTE_TUNE_EN
    if (cls >= 0 && m_valid && cls == m_pub) begin
      if (f > ref_ctr(cls) + TOL)      m_tune = 1;
      else if (f < ref_ctr(cls) - TOL) m_tune = 2;
      else                             m_tune = 0;
    end
`endif
    exp_q.push_back(pack_exp(m_valid, chg));
  endtask

  // One classification; glitch re-pulses note_dec mid-scan (needs a class of at least 6).
  task automatic send(input int f, input bit glitch);
    int cls, n;
    bit done;
    logic [17:0] exp_v, act_v;
    cls = classify(f);
    @(negedge clk);
    bus.frequency = f[BW:0];
    bus.note_dec  = 1'b1;
    model_step(f);
    @(posedge clk);
    n = 0;
    done = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (glitch && n == 3) bus.note_dec = 1'b0;
      if (glitch && n == 5) bus.note_dec = 1'b1;
      if (glitch && n == 6) check("busy_glitch", 32'(bus.busy), 32'd1);
      if (!bus.busy) done = 1;
    end
    check($sformatf("latency_f%0d", f), n, (cls < 0) ? 2 : cls + 3);
    @(negedge clk);
    act_v = {bus.note_valid, bus.note_change, bus.midi_note, bus.pitch_class, bus.octave, bus.tune};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check($sformatf("out_f%0d", f), 32'(act_v), 32'(exp_v));
    end else begin
      check("queue_underflow", 32'd1, 32'd0);
    end
    bus.note_dec = 1'b0;
    @(negedge clk);
    check("chg_one_cycle", 32'(bus.note_change), 32'd0);
  endtask

  task automatic send_n(input int f, input int reps);
    for (int i = 0; i < reps; i++) send(f, 1'b0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    bus.frequency = '0;
    bus.note_dec  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({bus.busy, bus.note_valid, bus.note_change, bus.midi_note,
                              bus.pitch_class, bus.octave, bus.tune}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // A4 three times, the middle one with an extra note_dec edge mid-scan.
    send(440, 1'b0);
    send(440, 1'b1);
    send(440, 1'b0);
    // Boundaries.
    send_n(452, 3);
    send_n(453, 3);
    send_n(64, 3);
    send_n(2032, 3);
    // Out of range withdraws without changing the note fields.
    send_n(440, 3);
    send_n(63, 3);
    send_n(440, 3);
    send_n(2033, 3);
    // Filter break, then a third consecutive A4.
    send(440, 1'b0); send(440, 1'b0); send(466, 1'b0); send(440, 1'b0); send(440, 1'b0);
    send(440, 1'b0);
    // Tune deviations around A4.
    send(445, 1'b0); send(435, 1'b0); send(441, 1'b0);

    // Random frequencies, each held for a random number of frames.
    repeat (20) begin
      int f, reps;
      f    = $urandom_range(40, 2100);
      reps = $urandom_range(1, 3);
      send_n(f, reps);
    end

    // Reset in the middle of a scan with a note published.
    send_n(440, 3);
    @(negedge clk);
    bus.frequency = 17'd440;
    bus.note_dec  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({bus.busy, bus.note_valid, bus.note_change, bus.midi_note,
                                  bus.pitch_class, bus.octave, bus.tune}), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.note_dec = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    send_n(262, 3);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
